// File: rtl/sir_uart_pkg.sv
// Shared types and constants for the sir_uart_tx serial transmitter.
package sir_uart_pkg;

  // Transmitter FSM states; PARITY is reachable only when SIR_UART_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_BITS   = 8;
  localparam int ERR_CNT_MAX = 255;

endpackage

// File: rtl/sir_fifo.sv
// Small synchronous FIFO buffering samples ahead of the serial transmitter.
// Pointers carry one extra wrap bit so full and empty are unambiguous.
// A write while full is legal only together with a read in the same cycle.
module sir_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic [AW:0]  count;
  logic [W-1:0] mem_q [DEPTH];

  // Read and write pointers advance on each accepted access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array written at the write pointer.
  // NOTE: the data array has no reset; emptiness is tracked by the pointers alone,
  // so stale contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/sir_uart_tx.sv
// sir_uart_tx: buffers (sir, tester) samples in a FIFO and shifts the data
// bytes out LSB first on a UART-style line (start, 8 data, stop). Also keeps
// a saturating count of disagreement cycles and a sticky overflow flag.
// Optional feature: define SIR_UART_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module sir_uart_tx
  import sir_uart_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int BAUD_DIV = 16,
  parameter int W        = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] in_data,
  input  logic         in_tester,
  output logic         tx,
  output logic         busy,
  output logic         full,
  output logic         drop,
  output logic [7:0]   err_cnt
);

  localparam int             BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [7:0]     ERR_MAX   = 8'(ERR_CNT_MAX);

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [W-1:0]  shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          drop_q, drop_d;
  logic [7:0]    err_q, err_d;
  logic          par_bit;

  logic          pop;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [W-1:0]  fifo_rd_data;

`ifdef SIR_UART_PARITY_EN
  logic par_q, par_d;
  assign par_bit = par_d;
`else
  assign par_bit = 1'b1;
`endif

  sir_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push    = en && (!fifo_full || pop);
  assign drop_d  = drop_q || (en && fifo_full && !pop);
  assign err_d   = (en && !in_tester && (err_q != ERR_MAX)) ? err_q + 8'd1 : err_q;

  // Frame sequencing, baud timing, shift register and the registered line level.
  // NOTE: every variable gets its default before the case; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef SIR_UART_PARITY_EN
    par_d   = par_q;
`endif
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
          baud_d  = '0;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[W-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef SIR_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      PARITY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture the next byte (and its parity) as it leaves the FIFO.
    if (pop) begin
      shift_d = fifo_rd_data;
`ifdef SIR_UART_PARITY_EN
      par_d   = ^fifo_rd_data;
`endif
    end

    // Line level follows the state being entered, so tx changes with the state.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs; reset drives the line high at once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= '0;
`ifdef SIR_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
`ifdef SIR_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign full    = fifo_full;
  assign drop    = drop_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_sir_uart_tx.sv
// Self-checking bench for sir_uart_tx (BAUD_DIV=4, DEPTH=4). A queue-based
// reference model predicts tx/busy/full/drop/err_cnt every cycle; frames are
// described as a bit list indexed by elapsed time within the frame.
module tb_sir_uart_tx;

  localparam int B  = 4;
  localparam int D  = 4;
`ifdef SIR_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FL = FRAME_BITS * B;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_tester = 1'b1;
  logic       tx, busy, full, drop;
  logic [7:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [7:0] mq[$];
  int         remaining = 0;
  logic [7:0] cur = 8'h00;
  bit         m_drop = 1'b0;
  int         m_err = 0;
  bit         m_pop, m_push;

  always #5 clk = ~clk;

  sir_uart_tx #(
    .DEPTH    (D),
    .BAUD_DIV (B),
    .W        (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_data   (in_data),
    .in_tester (in_tester),
    .tx        (tx),
    .busy      (busy),
    .full      (full),
    .drop      (drop),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level expected from the elapsed position inside the current frame.
  function automatic logic exp_tx();
    int idx;
    if (remaining == 0) return 1'b1;
    idx = (FL - remaining) / B;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return cur[idx-1];
`ifdef SIR_UART_PARITY_EN
    if (idx == 9) return ^cur;
`endif
    return 1'b1;
  endfunction

  task automatic model_clear();
    mq.delete();
    remaining = 0;
    m_drop    = 1'b0;
    m_err     = 0;
  endtask

  task automatic check_all(input string ph);
    check({ph, ".tx"},   tx,      exp_tx());
    check({ph, ".busy"}, busy,    remaining > 0);
    check({ph, ".full"}, full,    mq.size() == D);
    check({ph, ".drop"}, drop,    m_drop);
    check({ph, ".err"},  err_cnt, m_err);
  endtask

  // One clock cycle: drive inputs, predict, clock, update the model, compare.
  task automatic step(input string ph, input bit e, input logic [7:0] d, input bit t);
    en        = e;
    in_data   = d;
    in_tester = t;
    m_pop  = (mq.size() > 0) && (remaining <= 1);
    m_push = e && ((mq.size() < D) || m_pop);
    @(posedge clk);
    #1;
    if (m_pop) begin
      cur       = mq.pop_front();
      remaining = FL;
    end else if (remaining > 0) begin
      remaining--;
    end
    if (m_push) mq.push_back(d);
    else if (e) m_drop = 1'b1;
    if (e && !t && m_err < 255) m_err++;
    check_all(ph);
  endtask

  task automatic idle_steps(input string ph, input int n);
    for (int i = 0; i < n; i++) step(ph, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  // Hold reset with random inputs; outputs must sit at their reset values.
  task automatic apply_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en        = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      in_tester = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("rst.tx",   tx,      1'b1);
      check("rst.busy", busy,    1'b0);
      check("rst.full", full,    1'b0);
      check("rst.drop", drop,    1'b0);
      check("rst.err",  err_cnt, 8'd0);
    end
    en    = 1'b0;
    reset = 1'b0;
    model_clear();
  endtask

  int  busy_cnt;
  int  falls;
  bit  prev_busy;

  initial begin
    // Reset defaults, then 20 quiet cycles.
    apply_reset();
    idle_steps("quiet", 20);

    // Single frame of 0xA5: busy must be high for exactly one frame length.
    busy_cnt = 0;
    step("a5", 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < FL + 10; i++) begin
      step("a5", 1'b0, 8'($urandom), 1'b1);
      busy_cnt += int'(busy);
    end
    check("a5.busy_len", busy_cnt, FL);

    // Overflow: six pushes into a four-deep FIFO; five frames back-to-back.
    busy_cnt  = 0;
    falls     = 0;
    prev_busy = 1'b0;
    for (int i = 1; i <= 6 + 5 * FL + 10; i++) begin
      if (i <= 6) step("ovf", 1'b1, 8'(i), 1'b1);
      else        step("ovf", 1'b0, 8'($urandom), 1'b1);
      busy_cnt += int'(busy);
      if (prev_busy && !busy) falls++;
      prev_busy = busy;
    end
    check("ovf.busy_total", busy_cnt, 5 * FL);
    check("ovf.busy_falls", falls, 1);
    check("ovf.drop", drop, 1'b1);

    // Random traffic with occasional bursts, then drain.
    for (int i = 0; i < 800; i++) begin
      step("rnd", ($urandom_range(0, 15) == 0) || (i % 200 < 6), 8'($urandom),
           1'($urandom_range(0, 3) != 0));
    end
    idle_steps("drain", (D + 2) * FL);

    // Saturation of the error counter.
    apply_reset();
    for (int i = 0; i < 300; i++) step("sat", 1'b1, 8'($urandom), 1'b0);
    check("sat.err_255", err_cnt, 8'd255);
    for (int i = 0; i < 20; i++) step("sat_hold", 1'b1, 8'($urandom), 1'b1);
    check("sat.err_hold", err_cnt, 8'd255);

    // Reset asserted during the data bits of 0x3C (bit 0 = 0 on the line).
    apply_reset();
    step("mid", 1'b1, 8'h3C, 1'b1);
    idle_steps("mid", 6);
    check("mid.tx_low_before", tx, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("mid.tx_async", tx, 1'b1);
    check("mid.busy_async", busy, 1'b0);
    check("mid.full_async", full, 1'b0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < FL + 20; i++) begin
      step("mid_after", 1'b0, 8'($urandom), 1'b1);
      busy_cnt += int'(busy);
    end
    check("mid.no_resend", busy_cnt, 0);

`ifdef SIR_UART_PARITY_EN
    // Parity frames: 0x07 has odd weight (bit 1), 0x03 even weight (bit 0).
    apply_reset();
    step("par07", 1'b1, 8'h07, 1'b1);
    for (int i = 0; i < FL + 4; i++) begin
      step("par07", 1'b0, 8'($urandom), 1'b1);
      if (i == 9 * B + 1) check("par07.bit", tx, 1'b1);
    end
    step("par03", 1'b1, 8'h03, 1'b1);
    for (int i = 0; i < FL + 4; i++) begin
      step("par03", 1'b0, 8'($urandom), 1'b1);
      if (i == 9 * B + 1) check("par03.bit", tx, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
